shift_issue_stage: RTL and testbench

- Upstream feeder for the 32-bit shifter (SHIFT32): decodes R-type shift instructions into shifter operands D, S and LnR.
- Buffers decoded operations in a 2-entry elastic queue with valid/ready handshakes on both sides, so decode stalls and execute stalls decouple.
- Sits between the register-read stage and the shifter in the execute stage; flags non-shift functs and counts issued shifts.

---
 rtl/shift_issue_stage_pkg.sv | 25 ++
 rtl/shift_funct_decode.sv | 48 ++++
 rtl/shift_issue_stage.sv | 105 ++++++++++
 tb/tb_shift_issue_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue stage: funct codes, queue state encodings
// and the decoded-entry payload handed to SHIFT32.
package shift_issue_stage_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned ENTRY_W = DATA_W + DATA_W + 1;

  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h01;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SLLV = 6'h04;
  localparam logic [FUNCT_W-1:0] FN_SRLV = 6'h06;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] s;
    logic              lnr;
  } entry_t;

endpackage

// File: rtl/shift_funct_decode.sv
// Combinational funct/shamt/rt decoder into SHIFT32 operands.
// Variable-amount shifts (sllv/srlv) are decoded only when SHIFT_ISSUE_VAR_EN is defined.
module shift_funct_decode
  import shift_issue_stage_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  output logic               legal_c,
  output entry_t             entry_c
);

`ifndef SHIFT_ISSUE_VAR_EN
  logic unused_rt;
  assign unused_rt = ^rt_data;
`endif

  always_comb begin
    legal_c     = 1'b0;
    entry_c.d   = rs_data;
    entry_c.s   = DATA_W'(shamt);
    entry_c.lnr = 1'b0;
    case (funct)
      FN_SLL: begin
        legal_c     = 1'b1;
        entry_c.lnr = 1'b1;
      end
      FN_SRL: begin
        legal_c     = 1'b1;
      end
`ifdef SHIFT_ISSUE_VAR_EN
      // Full 32-bit amount passes through; SHIFT32 saturates >= 32 itself.
      FN_SLLV: begin
        legal_c     = 1'b1;
        entry_c.s   = rt_data;
        entry_c.lnr = 1'b1;
      end
      FN_SRLV: begin
        legal_c     = 1'b1;
        entry_c.s   = rt_data;
      end
`endif
      default: legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Decodes R-type shifts and buffers them in a 2-entry elastic queue ahead of SHIFT32.
// Optional sllv/srlv decode is enabled by defining SHIFT_ISSUE_VAR_EN.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [DATA_W-1:0]  in_rs_data,
  input  logic [DATA_W-1:0]  in_rt_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_D,
  output logic [DATA_W-1:0]  out_S,
  output logic               out_LnR,
  output logic               err_illegal,
  output logic [CNT_W-1:0]   issue_count
);

  logic       dec_legal;
  entry_t     dec_entry;

  logic [1:0] state, state_nxt;
  logic       head, head_nxt;
  logic       tail, tail_nxt;
  entry_t     mem [2];
  entry_t     mem_nxt [2];
  entry_t     head_entry_nxt;
  logic       accept, push, pop;

  shift_funct_decode u_decode (
    .funct   (in_funct),
    .shamt   (in_shamt),
    .rs_data (in_rs_data),
    .rt_data (in_rt_data),
    .legal_c (dec_legal),
    .entry_c (dec_entry)
  );

  // Next-state: queue occupancy, pointers and storage.
  always_comb begin
    accept         = in_valid & in_ready;
    push           = accept & dec_legal;
    pop            = out_valid & out_ready;
    state_nxt      = state;
    head_nxt       = head;
    tail_nxt       = tail;
    mem_nxt        = mem;

    case (state)
      ST_EMPTY: if (push) state_nxt = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_nxt = ST_FULL;
        else if (!push && pop) state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase

    if (push) begin
      mem_nxt[tail] = dec_entry;
      tail_nxt      = ~tail;
    end
    if (pop) head_nxt = ~head;

    // Outputs are registered copies of whatever will sit at the head next cycle.
    head_entry_nxt = mem_nxt[head_nxt];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_EMPTY;
      head        <= 1'b0;
      tail        <= 1'b0;
      mem[0]      <= '0;
      mem[1]      <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_D       <= '0;
      out_S       <= '0;
      out_LnR     <= 1'b0;
      err_illegal <= 1'b0;
      issue_count <= '0;
    end else begin
      state       <= state_nxt;
      head        <= head_nxt;
      tail        <= tail_nxt;
      mem[0]      <= mem_nxt[0];
      mem[1]      <= mem_nxt[1];
      in_ready    <= (state_nxt != ST_FULL);
      out_valid   <= (state_nxt != ST_EMPTY);
      out_D       <= head_entry_nxt.d;
      out_S       <= head_entry_nxt.s;
      out_LnR     <= head_entry_nxt.lnr;
      err_illegal <= accept & ~dec_legal;
      if (push) issue_count <= issue_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with a queue-based reference model checked every cycle.
module tb_shift_issue_stage;

  localparam int unsigned CNT_W = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_D;
  logic [31:0] out_S;
  logic        out_LnR;
  logic        err_illegal;
  logic [CNT_W-1:0] issue_count;

  int checks = 0;
  int errors = 0;

  shift_issue_stage #(.CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_shamt    (in_shamt),
    .in_rs_data  (in_rs_data),
    .in_rt_data  (in_rt_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_D       (out_D),
    .out_S       (out_S),
    .out_LnR     (out_LnR),
    .err_illegal (err_illegal),
    .issue_count (issue_count)
  );

  always #5 CLK = ~CLK;

  // Reference model: a plain queue of {D,S,LnR} values.
  typedef struct {
    logic [31:0] d;
    logic [31:0] s;
    logic        lnr;
  } op_t;

  op_t         m_q[$];
  logic        m_ready = 1'b1;
  logic        m_err   = 1'b0;
  int unsigned m_count = 0;
  bit          m_live  = 1'b0;

  function automatic bit model_decode(input logic [5:0] f, input logic [4:0] sh,
                                      input logic [31:0] rs, input logic [31:0] rt,
                                      output op_t op);
    op.d   = rs;
    op.s   = {27'b0, sh};
    op.lnr = 1'b0;
    if (f == 6'h01) begin op.lnr = 1'b1; return 1'b1; end
    if (f == 6'h02) return 1'b1;
`ifdef SHIFT_ISSUE_VAR_EN
    if (f == 6'h04) begin op.s = rt; op.lnr = 1'b1; return 1'b1; end
    if (f == 6'h06) begin op.s = rt; return 1'b1; end
`endif
    return 1'b0;
  endfunction

  always @(posedge CLK) begin
    op_t op;
    bit  acc, pop, legal;
    if (RST) begin
      m_q.delete();
      m_ready = 1'b1;
      m_err   = 1'b0;
      m_count = 0;
      m_live  = 1'b1;
    end else if (m_live) begin
      acc   = in_valid && m_ready;
      pop   = (m_q.size() != 0) && out_ready;
      legal = model_decode(in_funct, in_shamt, in_rs_data, in_rt_data, op);
      if (pop) void'(m_q.pop_front());
      if (acc && legal) begin
        m_q.push_back(op);
        m_count = (m_count + 1) % (1 << CNT_W);
      end
      m_err   = acc && !legal;
      m_ready = (m_q.size() < 2);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (m_live) begin
      check("in_ready", 64'(in_ready), 64'(m_ready));
      check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      check("err_illegal", 64'(err_illegal), 64'(m_err));
      check("issue_count", 64'(issue_count), 64'(m_count));
      if (m_q.size() != 0) begin
        check("out_D", 64'(out_D), 64'(m_q[0].d));
        check("out_S", 64'(out_S), 64'(m_q[0].s));
        check("out_LnR", 64'(out_LnR), 64'(m_q[0].lnr));
      end
    end
  end

  task automatic drive(input logic v, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic ordy);
    in_valid   = v;
    in_funct   = f;
    in_shamt   = sh;
    in_rs_data = rs;
    in_rt_data = rt;
    out_ready  = ordy;
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 6'h00, 5'd0, 32'h0, 32'h0, ordy);
  endtask

  initial begin
    RST = 1'b1;
    idle(1'b0);
    idle(1'b0);
    RST = 1'b0;

    // Reset values
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_D", 64'(out_D), 64'd0);
    check("rst_out_S", 64'(out_S), 64'd0);
    check("rst_count", 64'(issue_count), 64'd0);

    // sll shamt 4, one-cycle latency
    drive(1'b1, 6'h01, 5'd4, 32'h0000_00F1, 32'h0, 1'b0);
    check("sll_valid", 64'(out_valid), 64'd1);
    check("sll_D", 64'(out_D), 64'h0000_00F1);
    check("sll_S", 64'(out_S), 64'd4);
    check("sll_LnR", 64'(out_LnR), 64'd1);
    check("sll_count", 64'(issue_count), 64'd1);
    idle(1'b1);
    check("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: fill, stall a third op, then drain in order
    drive(1'b1, 6'h02, 5'd3, 32'hAAAA_0001, 32'h0, 1'b0);
    drive(1'b1, 6'h01, 5'd7, 32'hBBBB_0002, 32'h0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 6'h02, 5'd9, 32'hCCCC_0003, 32'h0, 1'b0);
    check("stall_count", 64'(issue_count), 64'd3);
    check("stall_head_S", 64'(out_S), 64'd3);
    check("stall_head_LnR", 64'(out_LnR), 64'd0);
    drive(1'b1, 6'h02, 5'd9, 32'hCCCC_0003, 32'h0, 1'b1);
    check("pop1_S", 64'(out_S), 64'd7);
    check("pop1_LnR", 64'(out_LnR), 64'd1);
    check("pop1_in_ready", 64'(in_ready), 64'd1);
    check("pop1_count", 64'(issue_count), 64'd3);
    // Third op accepted while second pops
    drive(1'b1, 6'h02, 5'd9, 32'hCCCC_0003, 32'h0, 1'b1);
    check("pp_S", 64'(out_S), 64'd9);
    check("pp_D", 64'(out_D), 64'hCCCC_0003);
    check("pp_count", 64'(issue_count), 64'd4);

    // Simultaneous push/pop in ONE with shamt 0
    drive(1'b1, 6'h01, 5'd0, 32'h1234_5678, 32'h0, 1'b1);
    check("pp1_valid", 64'(out_valid), 64'd1);
    check("pp1_S", 64'(out_S), 64'd0);
    check("pp1_D", 64'(out_D), 64'h1234_5678);
    check("pp1_count", 64'(issue_count), 64'd5);
    idle(1'b1);
    check("pp1_drain", 64'(out_valid), 64'd0);

    // Illegal funct: consumed, error pulse for exactly one cycle
    drive(1'b1, 6'h20, 5'd1, 32'hDEAD_BEEF, 32'h0, 1'b1);
    check("ill_err", 64'(err_illegal), 64'd1);
    check("ill_valid", 64'(out_valid), 64'd0);
    check("ill_count", 64'(issue_count), 64'd5);
    idle(1'b1);
    check("ill_err_clear", 64'(err_illegal), 64'd0);

    // Variable shift amount
    drive(1'b1, 6'h04, 5'd2, 32'h0F0F_0F0F, 32'h0000_0025, 1'b0);
`ifdef SHIFT_ISSUE_VAR_EN
    check("sllv_S", 64'(out_S), 64'h25);
    check("sllv_LnR", 64'(out_LnR), 64'd1);
    check("sllv_count", 64'(issue_count), 64'd6);
`else
    check("sllv_err", 64'(err_illegal), 64'd1);
    check("sllv_valid", 64'(out_valid), 64'd0);
    check("sllv_count", 64'(issue_count), 64'd5);
`endif
    idle(1'b1);
    idle(1'b1);

    // Reset while FULL with an op offered
    drive(1'b1, 6'h01, 5'd1, 32'h1, 32'h0, 1'b0);
    drive(1'b1, 6'h02, 5'd2, 32'h2, 32'h0, 1'b0);
    check("pre_rst_full", 64'(in_ready), 64'd0);
    RST = 1'b1;
    drive(1'b1, 6'h01, 5'd5, 32'h5, 32'h0, 1'b1);
    RST = 1'b0;
    check("rst_full_valid", 64'(out_valid), 64'd0);
    check("rst_full_ready", 64'(in_ready), 64'd1);
    check("rst_full_count", 64'(issue_count), 64'd0);
    idle(1'b1);
    check("rst_full_noenq", 64'(out_valid), 64'd0);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
